vga_timing_ctrl: RTL and testbench

- Run-time programmable video timing sequencer. Drives hcount/vcount, hsync, vsync and blank into the test-picture/pixel source and the vga2dvid encoder.
- A host loads a new mode into shadow registers; the block switches to it only at a frame boundary.
- After every switch it mutes video (blank forced) for a set number of frames so the DVI sink can resynchronise.
- Default mode after reset is 640x480@60 (800x525 total).

---
 rtl/vga_timing_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: run-time programmable video timing sequencer.
// Generates hcount/vcount, hsync, vsync, blank and frame_start for the pixel
// source and DVI encoder. A host loads a mode into shadow registers and
// commits it; the active mode only changes at a frame boundary, after which
// video is muted for MUTE_FRAMES frames so the sink can resynchronise.
// Optional feature macro: VGA_SYNC_POL_EN (address 8 = sync polarity,
// bit0 hsync active-low, bit1 vsync active-low).
`timescale 1ns/1ps
module vga_timing_ctrl #(
    parameter int CW          = 12,
    parameter int MUTE_FRAMES = 2
) (
    input  logic          clk_pixel,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    input  logic          cfg_commit,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          vga_hsync,
    output logic          vga_vsync,
    output logic          vga_blank,
    output logic          frame_start,
    output logic          pending,
    output logic          muted
);

    // Mute counter must hold MUTE_FRAMES; at least one bit even when muting is off.
    localparam int MW = $clog2(MUTE_FRAMES + 2);
    localparam logic [MW-1:0] MUTE_INIT = MW'(MUTE_FRAMES);

    typedef struct packed {
        logic [CW-1:0] h_vis;
        logic [CW-1:0] h_fp;
        logic [CW-1:0] h_sy;
        logic [CW-1:0] h_bp;
        logic [CW-1:0] v_vis;
        logic [CW-1:0] v_fp;
        logic [CW-1:0] v_sy;
        logic [CW-1:0] v_bp;
    } mode_t;

    typedef enum logic [1:0] {
        S_RUN,
        S_PENDING,
        S_MUTE
    } state_e;

    // 640x480@60, 800x525 total.
    function automatic mode_t reset_mode();
        mode_t m;
        m.h_vis = CW'(640);
        m.h_fp  = CW'(16);
        m.h_sy  = CW'(96);
        m.h_bp  = CW'(48);
        m.v_vis = CW'(480);
        m.v_fp  = CW'(10);
        m.v_sy  = CW'(2);
        m.v_bp  = CW'(33);
        return m;
    endfunction

    // A zero-length field would break the decode ranges; store it as 1.
    function automatic logic [CW-1:0] clamp_field(input logic [CW-1:0] val);
        return (val == '0) ? CW'(1) : val;
    endfunction

    function automatic logic in_visible(input logic [CW-1:0] cnt,
                                        input logic [CW-1:0] vis);
        return (cnt < vis);
    endfunction

    // Sync window [vis+fp, vis+fp+sy) evaluated with two guard bits.
    function automatic logic in_sync(input logic [CW-1:0] cnt,
                                     input logic [CW-1:0] vis,
                                     input logic [CW-1:0] fp,
                                     input logic [CW-1:0] sy);
        logic [CW+1:0] c;
        logic [CW+1:0] s0;
        logic [CW+1:0] s1;
        c  = {2'b00, cnt};
        s0 = {2'b00, vis} + {2'b00, fp};
        s1 = s0 + {2'b00, sy};
        return (c >= s0) && (c < s1);
    endfunction

    mode_t         shadow_q, shadow_d;
    mode_t         active_q, active_d;
    state_e        state_q, state_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic          muted_d;
    logic          swap;

    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic          hsync_q, vsync_q, blank_q, fstart_q, pending_q, muted_q;

    logic [CW-1:0] htot_m1, vtot_m1;
    logic          hwrap, vwrap, frame_end;
    logic          hs_raw, vs_raw, vis_d;

    logic [1:0]    pol_act_d;
`ifdef VGA_SYNC_POL_EN
    logic [1:0]    pol_sh_q, pol_sh_d;
    logic [1:0]    pol_act_q;
`endif

    // Shadow register file: host writes, clamped, no effect on active timing.
    always_comb begin
        shadow_d = shadow_q;
`ifdef VGA_SYNC_POL_EN
        pol_sh_d = pol_sh_q;
`endif
        if (cfg_we) begin
            case (cfg_addr)
                4'd0:    shadow_d.h_vis = clamp_field(cfg_wdata);
                4'd1:    shadow_d.h_fp  = clamp_field(cfg_wdata);
                4'd2:    shadow_d.h_sy  = clamp_field(cfg_wdata);
                4'd3:    shadow_d.h_bp  = clamp_field(cfg_wdata);
                4'd4:    shadow_d.v_vis = clamp_field(cfg_wdata);
                4'd5:    shadow_d.v_fp  = clamp_field(cfg_wdata);
                4'd6:    shadow_d.v_sy  = clamp_field(cfg_wdata);
                4'd7:    shadow_d.v_bp  = clamp_field(cfg_wdata);
`ifdef VGA_SYNC_POL_EN
                4'd8:    pol_sh_d = cfg_wdata[1:0];
`endif
                default: ;
            endcase
        end
    end

    // Frame geometry of the active mode and wrap detection.
    always_comb begin
        htot_m1   = (active_q.h_vis + active_q.h_fp + active_q.h_sy + active_q.h_bp) - CW'(1);
        vtot_m1   = (active_q.v_vis + active_q.v_fp + active_q.v_sy + active_q.v_bp) - CW'(1);
        hwrap     = (hcount_q == htot_m1);
        vwrap     = (vcount_q == vtot_m1);
        frame_end = hwrap && vwrap;
        hcount_d  = hwrap ? '0 : hcount_q + CW'(1);
        if (hwrap) begin
            vcount_d = vwrap ? '0 : vcount_q + CW'(1);
        end else begin
            vcount_d = vcount_q;
        end
    end

    // Mode-switch sequencing: commit, wait for frame end, swap, mute.
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        muted_d = muted_q;
        swap    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (cfg_commit) begin
                    if (frame_end) swap = 1'b1;
                    else           state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (frame_end) swap = 1'b1;
            end
            S_MUTE: begin
                if (cfg_commit) begin
                    if (frame_end) swap = 1'b1;
                    else           state_d = S_PENDING;
                end else if (frame_end) begin
                    if (mcnt_q <= MW'(1)) begin
                        state_d = S_RUN;
                        mcnt_d  = '0;
                        muted_d = 1'b0;
                    end else begin
                        mcnt_d = mcnt_q - MW'(1);
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
        if (swap) begin
            if (MUTE_FRAMES == 0) begin
                state_d = S_RUN;
                muted_d = 1'b0;
            end else begin
                state_d = S_MUTE;
                mcnt_d  = MUTE_INIT;
                muted_d = 1'b1;
            end
        end
    end

    // Next active mode and decodes of the next counter position.
    always_comb begin
        active_d = swap ? shadow_q : active_q;
`ifdef VGA_SYNC_POL_EN
        pol_act_d = swap ? pol_sh_q : pol_act_q;
`else
        pol_act_d = 2'b00;
`endif
        hs_raw = in_sync(hcount_d, active_d.h_vis, active_d.h_fp, active_d.h_sy);
        vs_raw = in_sync(vcount_d, active_d.v_vis, active_d.v_fp, active_d.v_sy);
        vis_d  = in_visible(hcount_d, active_d.h_vis) && in_visible(vcount_d, active_d.v_vis);
    end

    // Shadow and active mode registers.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= reset_mode();
            active_q <= reset_mode();
`ifdef VGA_SYNC_POL_EN
            pol_sh_q  <= 2'b00;
            pol_act_q <= 2'b00;
`endif
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
`ifdef VGA_SYNC_POL_EN
            pol_sh_q  <= pol_sh_d;
            pol_act_q <= pol_act_d;
`endif
        end
    end

    // Sequencer state and mute frame counter.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    // Counters and registered outputs, all describing the same pixel.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q  <= '0;
            vcount_q  <= '0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            blank_q   <= 1'b1;
            fstart_q  <= 1'b0;
            pending_q <= 1'b0;
            muted_q   <= 1'b0;
        end else begin
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            hsync_q   <= hs_raw ^ pol_act_d[0];
            vsync_q   <= vs_raw ^ pol_act_d[1];
            blank_q   <= !vis_d || muted_d;
            fstart_q  <= (hcount_d == '0) && (vcount_d == '0);
            pending_q <= (state_d == S_PENDING);
            muted_q   <= muted_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank   = blank_q;
    assign frame_start = fstart_q;
    assign pending     = pending_q;
    assign muted       = muted_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl: directed stimulus with hand-computed probes
// queued in a scoreboard; a monitor compares each probe at its cycle.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

    localparam int CW = 12;
`ifdef VGA_SYNC_POL_EN
    localparam bit HP = 1'b1;
    localparam bit VP = 1'b1;
`else
    localparam bit HP = 1'b0;
    localparam bit VP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [CW-1:0] cfg_wdata = '0;
    logic          cfg_commit = 1'b0;
    logic [CW-1:0] hcount, vcount;
    logic          vga_hsync, vga_vsync, vga_blank, frame_start, pending, muted;

    vga_timing_ctrl #(.CW(CW), .MUTE_FRAMES(2)) dut (
        .clk_pixel  (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_commit (cfg_commit),
        .hcount     (hcount),
        .vcount     (vcount),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync),
        .vga_blank  (vga_blank),
        .frame_start(frame_start),
        .pending    (pending),
        .muted      (muted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    t;
        int    h;
        int    v;
        bit    hs, vs, bl, fs, pd, mu;
        string nm;
    } probe_t;

    probe_t sbq[$];
    probe_t mon_p;
    int     tcyc = 0;
    int     base = 0;
    int     checks = 0;
    int     errors = 0;
    bit     done = 1'b0;

    always @(posedge clk) tcyc <= tcyc + 1;

    // k < 0 marks a probe checked immediately on reset assertion.
    task automatic push(input string nm, input int k, input int h, input int v,
                        input bit hs, input bit vs, input bit bl, input bit fs,
                        input bit pd, input bit mu);
        probe_t p;
        p.t = (k < 0) ? -1 : base + k;
        p.h = h; p.v = v; p.hs = hs; p.vs = vs; p.bl = bl;
        p.fs = fs; p.pd = pd; p.mu = mu; p.nm = nm;
        sbq.push_back(p);
    endtask

    task automatic compare_probe(input probe_t p);
        checks++;
        if (int'(hcount) != p.h || int'(vcount) != p.v || vga_hsync !== p.hs ||
            vga_vsync !== p.vs || vga_blank !== p.bl || frame_start !== p.fs ||
            pending !== p.pd || muted !== p.mu) begin
            errors++;
            $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b bl=%b fs=%b pd=%b mu=%b, expected h=%0d v=%0d hs=%b vs=%b bl=%b fs=%b pd=%b mu=%b",
                     p.nm, hcount, vcount, vga_hsync, vga_vsync, vga_blank, frame_start,
                     pending, muted, p.h, p.v, p.hs, p.vs, p.bl, p.fs, p.pd, p.mu);
        end
    endtask

    // Monitor: owns the check/error counts and the summary line.
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        if (done) begin
            while (sbq.size() > 0) begin
                mon_p = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: never observed, expected at cycle %0d", mon_p.nm, mon_p.t);
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
        if (!rst_n) begin
            if (sbq.size() > 0 && sbq[0].t < 0) begin
                mon_p = sbq.pop_front();
                compare_probe(mon_p);
            end
        end else begin
            while (sbq.size() > 0 && sbq[0].t <= tcyc) begin
                mon_p = sbq.pop_front();
                if (mon_p.t < tcyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: probe for cycle %0d skipped, now at %0d", mon_p.nm, mon_p.t, tcyc);
                end else begin
                    compare_probe(mon_p);
                end
            end
        end
    end

    initial begin
        #6_000_000;
        $display("FAIL watchdog: run did not complete, cycle %0d", tcyc);
        $fatal(1, "timeout");
    end

    task automatic wait_cyc(input int t);
        while (tcyc < t) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input int d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = CW'(d);
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        base = tcyc;

        // Default 640x480 (800x525), then switch to 1056-wide, 5-line mode.
        push("rst_vals",        0,    0,   0, 0, 0, 1, 0, 0, 0);
        push("first_px",        1,    1,   0, 0, 0, 0, 0, 0, 0);
        push("last_vis_h",    639,  639,   0, 0, 0, 0, 0, 0, 0);
        push("first_blank_h", 640,  640,   0, 0, 0, 1, 0, 0, 0);
        push("pre_hsync",     655,  655,   0, 0, 0, 1, 0, 0, 0);
        push("hsync_start",   656,  656,   0, 1, 0, 1, 0, 0, 0);
        push("hsync_last",    751,  751,   0, 1, 0, 1, 0, 0, 0);
        push("hsync_end",     752,  752,   0, 0, 0, 1, 0, 0, 0);
        push("line_end",      799,  799,   0, 0, 0, 1, 0, 0, 0);
        push("line1_start",   800,    0,   1, 0, 0, 0, 0, 0, 0);
        push("pre_commit",   1000,  200,   1, 0, 0, 0, 0, 0, 0);
        push("pending_set",  1001,  201,   1, 0, 0, 0, 0, 1, 0);
        push("pending_hold", 2500,  100,   3, 0, 0, 0, 0, 1, 0);
        push("last_vis_px", 383839, 639, 479, 0, 0, 0, 0, 1, 0);
        push("vblank_start",384000,   0, 480, 0, 0, 1, 0, 1, 0);
        push("pre_vsync",   391999, 799, 489, 0, 0, 1, 0, 1, 0);
        push("vsync_start", 392000,   0, 490, 0, 1, 1, 0, 1, 0);
        push("hv_sync",     392656, 656, 490, 1, 1, 1, 0, 1, 0);
        push("vsync_last",  393599, 799, 491, 0, 1, 1, 0, 1, 0);
        push("vsync_end",   393600,   0, 492, 0, 0, 1, 0, 1, 0);
        push("frame_last",  419999, 799, 524, 0, 0, 1, 0, 1, 0);
        push("switch",      420000,   0,   0, 0, 0, 1, 1, 0, 1);
        push("switch_p1",   420001,   1,   0, 0, 0, 1, 0, 0, 1);
        push("m_pre_hs",    420839, 839,   0, 0, 0, 1, 0, 0, 1);
        push("m_hs_start",  420840, 840,   0, 1, 0, 1, 0, 0, 1);
        push("m_hs_last",   420967, 967,   0, 1, 0, 1, 0, 0, 1);
        push("m_hs_end",    420968, 968,   0, 0, 0, 1, 0, 0, 1);
        push("m_line_end",  421055, 1055,  0, 0, 0, 1, 0, 0, 1);
        push("m_line1",     421056,   0,   1, 0, 0, 1, 0, 0, 1);
        push("m_pre_vs",    423167, 1055,  2, 0, 0, 1, 0, 0, 1);
        push("m_vs",        423168,   0,   3, 0, 1, 1, 0, 0, 1);
        push("m_vs_last",   424223, 1055,  3, 0, 1, 1, 0, 0, 1);
        push("m_line4",     424224,   0,   4, 0, 0, 1, 0, 0, 1);
        push("m_f1_last",   425279, 1055,  4, 0, 0, 1, 0, 0, 1);
        push("m_f2_start",  425280,   0,   0, 0, 0, 1, 1, 0, 1);
        push("m_f2_last",   430559, 1055,  4, 0, 0, 1, 0, 0, 1);
        push("unmute",      430560,   0,   0, 0, 0, 0, 1, 0, 0);
        push("unmute_p1",   430561,   1,   0, 0, 0, 0, 0, 0, 0);
        push("c2_pre",      431010, 450,   0, 0, 0, 0, 0, 0, 0);
        push("c2_pending",  431011, 451,   0, 0, 0, 0, 0, 1, 0);
        push("n_last_vis",  431359, 799,   0, 0, 0, 0, 0, 1, 0);
        push("n_hblank",    431360, 800,   0, 0, 0, 1, 0, 1, 0);
        push("n_vblank",    432672,   0,   2, 0, 0, 1, 0, 1, 0);

        wait_cyc(base + 900);
        wr(0, 800); wr(1, 40); wr(2, 128); wr(3, 88);
        wr(4, 600); wr(5, 1);  wr(6, 4);   wr(7, 23);
        wait_cyc(base + 1000);
        commit();
        wait_cyc(base + 2000);
        commit();
        wr(4, 2); wr(5, 1); wr(6, 1); wr(7, 1);

        // h_sync written as 0 plus polarity and an out-of-map address.
        wait_cyc(base + 431000);
        push("b_old_last",  435839, 1055,  4, 0, 0, 1, 0, 1, 0);
        push("b_switch",    435840,   0,   0, HP, VP, 1, 1, 0, 1);
        push("b_mute_pend", 436501, 661,   0, HP, VP, 1, 0, 1, 1);
        push("b_pre_hs",    436679, 839,   0, HP, VP, 1, 0, 1, 1);
        push("b_hs_pulse",  436680, 840,   0, 1'b1 ^ HP, VP, 1, 0, 1, 1);
        push("b_hs_after",  436681, 841,   0, HP, VP, 1, 0, 1, 1);
        push("b_line_end",  436768, 928,   0, HP, VP, 1, 0, 1, 1);
        push("b_line1",     436769,   0,   1, HP, VP, 1, 0, 1, 1);
        push("b_hs_line1",  437609, 840,   1, 1'b1 ^ HP, VP, 1, 0, 1, 1);
        push("b_hs1_after", 437610, 841,   1, HP, VP, 1, 0, 1, 1);
        push("b_pre_vs",    438626, 928,   2, HP, VP, 1, 0, 1, 1);
        push("b_vs",        438627,   0,   3, HP, 1'b1 ^ VP, 1, 0, 1, 1);
        wr(2, 0); wr(8, 3); wr(12, 7);
        wait_cyc(base + 431010);
        commit();
        wait_cyc(base + 436500);
        commit();

        // Asynchronous reset while muted with a switch pending.
        wait_cyc(base + 440000);
        @(posedge clk);
        #3;
        push("async_rst",      -1,    0,   0, 0, 0, 1, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        base = tcyc;
        push("r_vals",          0,    0,   0, 0, 0, 1, 0, 0, 0);
        push("r_first_px",      1,    1,   0, 0, 0, 0, 0, 0, 0);
        push("r_hsync",       656,  656,   0, 1, 0, 1, 0, 0, 0);
        push("r_line1",       800,    0,   1, 0, 0, 0, 0, 0, 0);
        push("r_no_switch",  1500,  700,   1, 1, 0, 1, 0, 0, 0);
        wait_cyc(base + 1600);
        done = 1'b1;
    end

endmodule
